// File: rtl/seven_seg_scan.sv
// Multiplexed 7-segment driver: scans DIGITS nibbles over one shared segment bus with
// leading-zero blanking, per-digit decimal points, a guard interval and frame-synchronous loads.
module seven_seg_scan #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned DIV            = 1000,
  parameter int unsigned GUARD          = 2,
  parameter bit          HEX_EN         = 1'b0,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_done
);

  localparam int unsigned PW = $clog2(DIV);
  localparam int unsigned IW = $clog2(DIGITS);
  localparam logic [PW-1:0] PLast  = PW'(DIV - 1);
  localparam logic [PW-1:0] GuardP = PW'(GUARD);
  localparam logic [IW-1:0] IdxLast = IW'(DIGITS - 1);

  logic [PW-1:0]          p_q, p_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [4*DIGITS-1:0]    pend_q, pend_d, act_q, act_d;
  logic [DIGITS-1:0]      pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic                   pend_v_q, pend_v_d;
  logic [6:0]             seg_q, seg_d;
  logic                   dp_q, dp_d;
  logic [DIGITS-1:0]      dig_q, dig_d;
  logic                   fd_q, fd_d;

  logic                   slot_end, wrap, xfer;
  logic [3:0]             nib_cur;
  logic                   dp_cur, blank_cur, zero_run;
  logic [DIGITS-1:0]      dig_cur, upper_zero;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h7E;
      4'h1:    s = 7'h30;
      4'h2:    s = 7'h6D;
      4'h3:    s = 7'h79;
      4'h4:    s = 7'h33;
      4'h5:    s = 7'h5B;
      4'h6:    s = 7'h5F;
      4'h7:    s = 7'h70;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h7B;
      4'hA:    s = HEX_EN ? 7'h77 : 7'h00;
      4'hB:    s = HEX_EN ? 7'h1F : 7'h00;
      4'hC:    s = HEX_EN ? 7'h4E : 7'h00;
      4'hD:    s = HEX_EN ? 7'h3D : 7'h00;
      4'hE:    s = HEX_EN ? 7'h4F : 7'h00;
      default: s = HEX_EN ? 7'h47 : 7'h00;
    endcase
    return s;
  endfunction

  assign slot_end = (p_q == PLast);
  assign wrap     = en && slot_end && (idx_q == IdxLast);
  // With the scan stopped there is no frame to tear, so pending data moves across at once.
  assign xfer     = !en || wrap;

  always_comb begin
    p_d   = '0;
    idx_d = '0;
    if (en) begin
      if (slot_end) begin
        p_d   = '0;
        idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
      end else begin
        p_d   = p_q + 1'b1;
        idx_d = idx_q;
      end
    end
  end

  always_comb begin
    pend_d    = pend_q;
    pend_dp_d = pend_dp_q;
    pend_v_d  = pend_v_q;
    act_d     = act_q;
    act_dp_d  = act_dp_q;
    if (load) begin
      if (xfer) begin
        act_d    = bcd_in;
        act_dp_d = dp_in;
        pend_v_d = 1'b0;
      end else begin
        pend_d    = bcd_in;
        pend_dp_d = dp_in;
        pend_v_d  = 1'b1;
      end
    end else if (xfer && pend_v_q) begin
      act_d    = pend_q;
      act_dp_d = pend_dp_q;
      pend_v_d = 1'b0;
    end
  end

  // upper_zero[k]: nibble k and every nibble above it are zero.
  always_comb begin
    upper_zero = '0;
    zero_run   = 1'b1;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      zero_run      = zero_run && (act_q[4*k +: 4] == 4'h0);
      upper_zero[k] = zero_run;
    end
  end

  always_comb begin
    nib_cur   = '0;
    dp_cur    = 1'b0;
    blank_cur = 1'b0;
    dig_cur   = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (idx_q == IW'(k)) begin
        nib_cur    = act_q[4*k +: 4];
        dp_cur     = act_dp_q[k];
        blank_cur  = blank_lz && (k != 0) && upper_zero[k];
        dig_cur[k] = 1'b1;
      end
    end
  end

  always_comb begin
    seg_d = (en && !blank_cur) ? decode(nib_cur) : 7'h00;
    dp_d  = en && dp_cur;
    dig_d = (en && (p_q >= GuardP)) ? dig_cur : '0;
    fd_d  = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q       <= '0;
      idx_q     <= '0;
      pend_q    <= '0;
      pend_dp_q <= '0;
      pend_v_q  <= 1'b0;
      act_q     <= '0;
      act_dp_q  <= '0;
      seg_q     <= '0;
      dp_q      <= 1'b0;
      dig_q     <= '0;
      fd_q      <= 1'b0;
    end else begin
      p_q       <= p_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      pend_dp_q <= pend_dp_d;
      pend_v_q  <= pend_v_d;
      act_q     <= act_d;
      act_dp_q  <= act_dp_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      dig_q     <= dig_d;
      fd_q      <= fd_d;
    end
  end

  // Registers hold active-high values; polarity is applied at the pins so reset is inactive.
  assign seg        = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
  assign dp         = SEG_ACTIVE_LOW ? ~dp_q : dp_q;
  assign dig_sel    = DIG_ACTIVE_LOW ? ~dig_q : dig_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: two instances (decimal/active-high and hex/active-low)
// checked every cycle against a frame-time reference model.
module tb_seven_seg_scan;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned DIV    = 4;
  localparam int unsigned GUARD  = 1;
  localparam int          FRAME  = DIGITS * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [3:0]  dp_in = '0;

  logic [6:0]  a_seg, b_seg;
  logic        a_dp, b_dp, a_fd, b_fd;
  logic [3:0]  a_dig, b_dig;

  always #5 clk = ~clk;

  seven_seg_scan #(
    .DIGITS(DIGITS), .DIV(DIV), .GUARD(GUARD),
    .HEX_EN(1'b0), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg(a_seg), .dp(a_dp), .dig_sel(a_dig), .frame_done(a_fd)
  );

  seven_seg_scan #(
    .DIGITS(DIGITS), .DIV(DIV), .GUARD(GUARD),
    .HEX_EN(1'b1), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg(b_seg), .dp(b_dp), .dig_sel(b_dig), .frame_done(b_fd)
  );

  typedef struct packed {
    logic [6:0] seg_a;
    logic [6:0] seg_b;
    logic       dp;
    logic [3:0] dig;
    logic       fd;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [6:0] seg_tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  function automatic logic [6:0] ref_decode(input logic [3:0] n, input bit hex);
    if (n > 4'd9 && !hex) return 7'h00;
    return seg_tbl[n];
  endfunction

  // Reference model state: t counts enabled cycles since the scan (re)started.
  int          t = 0;
  logic [15:0] m_act = '0, m_pend = '0;
  logic [3:0]  m_act_dp = '0, m_pend_dp = '0;
  bit          m_pv = 1'b0;

  initial begin
    exp_t e;
    int   p, idx;
    bit   blanked, wrap, xfer;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        sb.delete();
        t = 0; m_act = '0; m_pend = '0; m_act_dp = '0; m_pend_dp = '0; m_pv = 1'b0;
      end else begin
        e   = '0;
        p   = t % DIV;
        idx = (t / DIV) % DIGITS;
        if (en) begin
          blanked = blank_lz && (idx != 0) && ((m_act >> (4 * idx)) == 16'h0);
          e.seg_a = blanked ? 7'h00 : ref_decode(m_act[4*idx +: 4], 1'b0);
          e.seg_b = blanked ? 7'h00 : ref_decode(m_act[4*idx +: 4], 1'b1);
          e.dp    = m_act_dp[idx];
          e.dig   = (p >= int'(GUARD)) ? 4'(1 << idx) : 4'h0;
          e.fd    = (t % FRAME) == FRAME - 1;
        end
        sb.push_back(e);
        wrap = en && ((t % FRAME) == FRAME - 1);
        xfer = !en || wrap;
        if (load) begin
          if (xfer) begin
            m_act = bcd_in; m_act_dp = dp_in; m_pv = 1'b0;
          end else begin
            m_pend = bcd_in; m_pend_dp = dp_in; m_pv = 1'b1;
          end
        end else if (xfer && m_pv) begin
          m_act = m_pend; m_act_dp = m_pend_dp; m_pv = 1'b0;
        end
        t = en ? t + 1 : 0;
      end
    end
  end

  task automatic check(input string name, input logic [12:0] got, input logic [12:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s at %0t: got seg/dp/dig/fd=%h expected %h", name, $time, got, want);
    end
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_a"}, {a_seg, a_dp, a_dig, a_fd}, 13'h0000);
    check({tag, "_b"}, {b_seg, b_dp, b_dig, b_fd}, {7'h7F, 1'b1, 4'hF, 1'b0});
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check_reset_pins("reset");
      end else if (sb.size() > 0) begin
        e = sb.pop_front();
        check("dec_hi", {a_seg, a_dp, a_dig, a_fd}, {e.seg_a, e.dp, e.dig, e.fd});
        check("hex_lo", {b_seg, b_dp, b_dig, b_fd}, {~e.seg_b, ~e.dp, ~e.dig, e.fd});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_val(input logic [15:0] v, input logic [3:0] d);
    bcd_in = v; dp_in = d; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Align so the next sampling edge sees the given in-frame phase; bounded.
  task automatic wait_phase(input int ph);
    int guard_cnt = 0;
    while ((t % FRAME) != ph && guard_cnt < 4 * FRAME) begin
      tick();
      guard_cnt++;
    end
    if ((t % FRAME) != ph) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_phase: phase %0d required %0d", t % FRAME, ph);
    end
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    en = 1'b1;
    load_val(16'h1234, 4'b0101);
    repeat (40) tick();

    for (int n = 0; n < 16; n++) begin
      load_val({12'h000, 4'(n)}, 4'(n));
      repeat (33) tick();
    end

    blank_lz = 1'b1;
    load_val(16'h0040, 4'b1000);
    repeat (40) tick();
    load_val(16'h0000, 4'b0110);
    repeat (40) tick();
    blank_lz = 1'b0;

    wait_phase(5);
    load_val(16'h1111, 4'b0001);
    repeat (3) tick();
    load_val(16'h2222, 4'b0010);
    repeat (40) tick();

    wait_phase(FRAME - 1);
    load_val(16'h5678, 4'b1100);
    repeat (20) tick();

    repeat (7) tick();
    en = 1'b0;
    repeat (5) tick();
    en = 1'b1;
    repeat (20) tick();

    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    check_reset_pins("async_rst");
    repeat (2) tick();
    rst_n = 1'b1;
    load_val(16'h0907, 4'b1010);
    repeat (40) tick();

    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 15) != 0);
      load = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < 4; k++)
        bcd_in[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      dp_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      tick();
    end
    load = 1'b0;
    en   = 1'b1;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
